// File: rtl/recur_seq_gen.sv
// recur_seq_gen
// -------------
// Streams the terms of a small linear recurrence (Fibonacci, Pell,
// Tribonacci or Jacobsthal) over a valid/ready output port. Start samples the
// mode, seeds and length. Each term is then offered with its index until the
// consumer takes it. Overflowing sums either wrap or saturate, depending on
// SAT. A sticky flag reports that some term of the current sequence
// overflowed.
//
// Ports
//   clk          clock, all logic on the rising edge
//   rst_n        asynchronous active-low reset
//   start_i      request a new sequence (only honoured when idle)
//   abort_i      synchronous cancel of a running sequence
//   mode_i       recurrence select: 0 Fib, 1 Pell, 2 Tribonacci, 3 Jacobsthal
//   seed0_i..2_i initial terms t0, t1, t2 (t2 used in Tribonacci only)
//   len_i        number of terms to emit (0 gives an immediate done)
//   out_ready_i  consumer accepts the presented term
//   out_valid_o  out_data_o holds a term
//   out_data_o   current term
//   out_idx_o    index of the current term, starting at 0
//   out_last_o   the current term is the final one
//   overflow_o   sticky overflow flag for the current sequence
//   busy_o       a sequence is being emitted
//   done_o       one-cycle pulse at normal completion
module recur_seq_gen #(
  parameter int W     = 16,
  parameter int CNT_W = 8,
  parameter bit SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [1:0]       mode_i,
  input  logic [W-1:0]     seed0_i,
  input  logic [W-1:0]     seed1_i,
  input  logic [W-1:0]     seed2_i,
  input  logic [CNT_W-1:0] len_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [W-1:0]     out_data_o,
  output logic [CNT_W-1:0] out_idx_o,
  output logic             out_last_o,
  output logic             overflow_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam int SW = W + 2;
  localparam logic [SW-1:0]    MAX_TERM = {2'b00, {W{1'b1}}};
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO      = CNT_W'(2);

  state_t           state_q;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] idx_q;
  logic [W-1:0]     cur_q;
  logic [W-1:0]     prev1_q;
  logic [W-1:0]     prev2_q;
  logic [W-1:0]     seed1_q;
  logic [W-1:0]     seed2_q;
  logic             valid_q;
  logic             last_q;
  logic             ovf_q;
  logic             busy_q;
  logic             done_q;

  logic [SW-1:0]    curX;
  logic [SW-1:0]    p1X;
  logic [SW-1:0]    p2X;
  logic [SW-1:0]    sum_d;
  logic [W-1:0]     next_d;
  logic             nextOvf_d;
  logic [CNT_W-1:0] idxNext_d;
  logic             lastNext_d;

  // Next term, computed from the history of the term now on the port.
  // The sums are formed two bits wider than a term so that no carry is lost
  // before the overflow test. Index 1 always comes from seed1. Index 2 comes
  // from seed2 only in Tribonacci mode. In every other case the recurrence
  // result is used.
  always_comb begin
    curX = {2'b00, cur_q};
    p1X  = {2'b00, prev1_q};
    p2X  = {2'b00, prev2_q};
    case (mode_q)
      2'd0:    sum_d = curX + p1X;
      2'd1:    sum_d = (curX << 1) + p1X;
      2'd2:    sum_d = curX + p1X + p2X;
      default: sum_d = curX + (p1X << 1);
    endcase

    idxNext_d  = idx_q + ONE;
    lastNext_d = (idxNext_d == (len_q - ONE));
    nextOvf_d  = 1'b0;

    if (idxNext_d == ONE) begin
      next_d = seed1_q;
    end else if ((idxNext_d == TWO) && (mode_q == 2'd2)) begin
      next_d = seed2_q;
    end else if (sum_d > MAX_TERM) begin
      nextOvf_d = 1'b1;
      next_d    = SAT ? {W{1'b1}} : sum_d[W-1:0];
    end else begin
      next_d = sum_d[W-1:0];
    end
  end

  // Control FSM with registered outputs. On each transfer the history shifts
  // by one term. The overflow flag is updated in the same cycle, so it rises
  // together with the first overflowed term on the port. A start with len=0
  // goes straight to FIN and pulses done without presenting any term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      mode_q  <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      cur_q   <= '0;
      prev1_q <= '0;
      prev2_q <= '0;
      seed1_q <= '0;
      seed2_q <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            mode_q  <= mode_i;
            len_q   <= len_i;
            seed1_q <= seed1_i;
            seed2_q <= seed2_i;
            cur_q   <= seed0_i;
            prev1_q <= '0;
            prev2_q <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
            if (len_i != '0) begin
              state_q <= RUN;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              last_q  <= (len_i == ONE);
            end else begin
              state_q <= FIN;
              done_q  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (abort_i) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
          end else if (valid_q && out_ready_i) begin
            if (last_q) begin
              state_q <= FIN;
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              prev2_q <= prev1_q;
              prev1_q <= cur_q;
              cur_q   <= next_d;
              idx_q   <= idxNext_d;
              last_q  <= lastNext_d;
              ovf_q   <= ovf_q | nextOvf_d;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign out_valid_o = valid_q;
  assign out_data_o  = cur_q;
  assign out_idx_o   = idx_q;
  assign out_last_o  = last_q;
  assign overflow_o  = ovf_q;
  assign busy_o      = busy_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_recur_seq_gen.sv
`timescale 1ns/1ps
// Testbench for recur_seq_gen. It runs a wrapping (SAT=0) instance and a
// saturating (SAT=1) instance side by side, with W=8 and CNT_W=8. Both
// instances get the same stimulus. A reference model in the bench pushes the
// expected terms into two queues when a sequence is started. The scoreboard
// pops one entry per observed transfer.
module tb_recur_seq_gen;

  localparam int W  = 8;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    mode = '0;
  logic [W-1:0]  seed0 = '0;
  logic [W-1:0]  seed1 = '0;
  logic [W-1:0]  seed2 = '0;
  logic [CW-1:0] len = '0;
  logic          outReady = 1'b1;

  logic          wValid, wLast, wOvf, wBusy, wDone;
  logic [W-1:0]  wData;
  logic [CW-1:0] wIdx;
  logic          sValid, sLast, sOvf, sBusy, sDone;
  logic [W-1:0]  sData;
  logic [CW-1:0] sIdx;

  recur_seq_gen #(.W(W), .CNT_W(CW), .SAT(1'b0)) dutWrap (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .mode_i(mode),
    .seed0_i(seed0), .seed1_i(seed1), .seed2_i(seed2), .len_i(len),
    .out_ready_i(outReady), .out_valid_o(wValid), .out_data_o(wData),
    .out_idx_o(wIdx), .out_last_o(wLast), .overflow_o(wOvf), .busy_o(wBusy),
    .done_o(wDone)
  );

  recur_seq_gen #(.W(W), .CNT_W(CW), .SAT(1'b1)) dutSat (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort), .mode_i(mode),
    .seed0_i(seed0), .seed1_i(seed1), .seed2_i(seed2), .len_i(len),
    .out_ready_i(outReady), .out_valid_o(sValid), .out_data_o(sData),
    .out_idx_o(sIdx), .out_last_o(sLast), .overflow_o(sOvf), .busy_o(sBusy),
    .done_o(sDone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  data;
    logic [CW-1:0] idx;
    logic          last;
    logic          ovf;
  } expT;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] s0;
    logic [W-1:0] s1;
    logic [W-1:0] s2;
    int           len;
    logic [W-1:0] lastW;
    logic [W-1:0] lastS;
    logic         ovf;
  } vecT;

  expT          expW[$];
  expT          expS[$];
  expT          eW;
  expT          eS;
  int           checks = 0;
  int           failures = 0;
  int           cycle = 0;
  int           lastXferCycle = -10;
  logic [W-1:0] lastDataW = '0;
  logic [W-1:0] lastDataS = '0;
  vecT          vecs[10];

  // Free-running cycle count, used to time done against the last transfer.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model. It builds the expected stream for both instances with
  // plain integer arithmetic and applies the wrap or clamp rule itself.
  task automatic pushModel(input logic [1:0] m, input int a, input int b, input int c, input int n);
    int  tw[0:511];
    int  ts[0:511];
    int  vw;
    int  vs;
    int  maxV;
    bit  ow;
    bit  os;
    expT e;
    maxV = (1 << W) - 1;
    ow = 1'b0;
    os = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        vw = a; vs = a;
      end else if (i == 1) begin
        vw = b; vs = b;
      end else if (i == 2 && m == 2'd2) begin
        vw = c; vs = c;
      end else begin
        case (m)
          2'd0: begin vw = tw[i-1] + tw[i-2]; vs = ts[i-1] + ts[i-2]; end
          2'd1: begin vw = 2*tw[i-1] + tw[i-2]; vs = 2*ts[i-1] + ts[i-2]; end
          2'd2: begin vw = tw[i-1] + tw[i-2] + tw[i-3]; vs = ts[i-1] + ts[i-2] + ts[i-3]; end
          default: begin vw = tw[i-1] + 2*tw[i-2]; vs = ts[i-1] + 2*ts[i-2]; end
        endcase
      end
      if (vw > maxV) begin ow = 1'b1; vw = vw % (maxV + 1); end
      if (vs > maxV) begin os = 1'b1; vs = maxV; end
      tw[i] = vw;
      ts[i] = vs;
      e.data = vw[W-1:0]; e.idx = i[CW-1:0]; e.last = (i == n-1); e.ovf = ow;
      expW.push_back(e);
      e.data = vs[W-1:0]; e.ovf = os;
      expS.push_back(e);
    end
  endtask

  // Scoreboard: one expected entry is popped per transfer on each instance.
  always @(negedge clk) begin
    if (rst_n && wValid && outReady) begin
      if (expW.size() == 0) begin
        checkOutput("wrapUnexpectedTerm", {24'd0, wData}, 32'hFFFF_FFFF);
      end else begin
        eW = expW.pop_front();
        checkOutput("wrapData", {24'd0, wData}, {24'd0, eW.data});
        checkOutput("wrapIdx", {24'd0, wIdx}, {24'd0, eW.idx});
        checkOutput("wrapLast", {31'd0, wLast}, {31'd0, eW.last});
        checkOutput("wrapOvf", {31'd0, wOvf}, {31'd0, eW.ovf});
        lastDataW = wData;
        if (eW.last) lastXferCycle = cycle;
      end
    end
    if (rst_n && sValid && outReady) begin
      if (expS.size() == 0) begin
        checkOutput("satUnexpectedTerm", {24'd0, sData}, 32'hFFFF_FFFF);
      end else begin
        eS = expS.pop_front();
        checkOutput("satData", {24'd0, sData}, {24'd0, eS.data});
        checkOutput("satIdx", {24'd0, sIdx}, {24'd0, eS.idx});
        checkOutput("satOvf", {31'd0, sOvf}, {31'd0, eS.ovf});
        lastDataS = sData;
      end
    end
  end

  task automatic flushQueues();
    expW.delete();
    expS.delete();
  endtask

  // Present a start for one cycle and record its expected stream. The inputs
  // are scrambled afterwards, so a design that resamples them is caught.
  task automatic applyStimulus(input logic [1:0] m, input int a, input int b, input int c,
                               input int n, input bit withAbort);
    @(posedge clk); #1;
    pushModel(m, a, b, c, n);
    start = 1'b1; abort = withAbort; mode = m;
    seed0 = a[W-1:0]; seed1 = b[W-1:0]; seed2 = c[W-1:0]; len = n[CW-1:0];
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    mode = 2'($urandom); seed0 = 8'($urandom); seed1 = 8'($urandom);
    seed2 = 8'($urandom); len = 8'($urandom);
  endtask

  task automatic waitDone(input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (wDone) seen = 1'b1;
    end
    checkOutput("doneSeen", {31'd0, seen}, 32'd1);
    if (seen) begin
      checkOutput("doneLatency", cycle, lastXferCycle + 1);
      checkOutput("queueDrained", expW.size(), 0);
      checkOutput("satDoneAgrees", {31'd0, sDone}, 32'd1);
    end
    flushQueues();
  endtask

  task automatic waitIdx(input int target, output bit found);
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      @(posedge clk); #1;
      if (wValid && wIdx == target[CW-1:0]) found = 1'b1;
    end
  endtask

  task automatic runAbort(input int n, input int at, input bit expOvf);
    bit found;
    bit anyDone;
    applyStimulus(2'd0, 0, 1, 0, n, 1'b0);
    waitIdx(at, found);
    checkOutput("abortIdxReached", {31'd0, found}, 32'd1);
    abort = 1'b1; outReady = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0; outReady = 1'b1;
    @(negedge clk);
    checkOutput("abortValid", {31'd0, wValid}, 32'd0);
    checkOutput("abortBusy", {31'd0, wBusy}, 32'd0);
    checkOutput("abortOvfHeld", {31'd0, wOvf}, {31'd0, expOvf});
    anyDone = wDone;
    repeat (4) begin
      @(negedge clk);
      anyDone = anyDone | wDone | wValid;
    end
    checkOutput("abortNoDoneNoValid", {31'd0, anyDone}, 32'd0);
    flushQueues();
  endtask

  initial begin : watchdog
    #2000000;
    $display("[TB] FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit found;
    bit sawValid;

    vecs[0] = '{2'd0, 8'd0,   8'd1,   8'd99, 10,  8'd34,  8'd34,  1'b0};
    vecs[1] = '{2'd1, 8'd0,   8'd1,   8'd0,  6,   8'd29,  8'd29,  1'b0};
    vecs[2] = '{2'd2, 8'd0,   8'd0,   8'd1,  7,   8'd7,   8'd7,   1'b0};
    vecs[3] = '{2'd3, 8'd0,   8'd1,   8'd0,  6,   8'd11,  8'd11,  1'b0};
    vecs[4] = '{2'd0, 8'd0,   8'd1,   8'd0,  15,  8'd121, 8'd255, 1'b1};
    vecs[5] = '{2'd2, 8'd7,   8'd9,   8'd11, 1,   8'd7,   8'd7,   1'b0};
    vecs[6] = '{2'd2, 8'd1,   8'd2,   8'd3,  5,   8'd11,  8'd11,  1'b0};
    vecs[7] = '{2'd1, 8'd100, 8'd200, 8'd0,  4,   8'd176, 8'd255, 1'b1};
    vecs[8] = '{2'd3, 8'd255, 8'd255, 8'd0,  3,   8'd253, 8'd255, 1'b1};
    vecs[9] = '{2'd0, 8'd0,   8'd0,   8'd0,  255, 8'd0,   8'd0,   1'b0};

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    checkOutput("rstValid", {31'd0, wValid}, 32'd0);
    checkOutput("rstBusy", {31'd0, wBusy}, 32'd0);
    checkOutput("rstDone", {31'd0, wDone}, 32'd0);
    checkOutput("rstData", {24'd0, wData}, 32'd0);
    checkOutput("rstIdx", {24'd0, wIdx}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Table-driven sequences
    for (int v = 0; v < 10; v++) begin
      applyStimulus(vecs[v].mode, vecs[v].s0, vecs[v].s1, vecs[v].s2, vecs[v].len, 1'b0);
      waitDone(vecs[v].len + 20);
      checkOutput($sformatf("vec%0dLastWrap", v), {24'd0, lastDataW}, {24'd0, vecs[v].lastW});
      checkOutput($sformatf("vec%0dLastSat", v), {24'd0, lastDataS}, {24'd0, vecs[v].lastS});
      checkOutput($sformatf("vec%0dOvfWrap", v), {31'd0, wOvf}, {31'd0, vecs[v].ovf});
      checkOutput($sformatf("vec%0dOvfSat", v), {31'd0, sOvf}, {31'd0, vecs[v].ovf});
    end

    // Backpressure on idx 4 of the Fibonacci sequence
    applyStimulus(2'd0, 0, 1, 0, 10, 1'b0);
    waitIdx(4, found);
    checkOutput("bpIdxReached", {31'd0, found}, 32'd1);
    outReady = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("bpValidHeld", {31'd0, wValid}, 32'd1);
      checkOutput("bpDataHeld", {24'd0, wData}, 32'd3);
      checkOutput("bpIdxHeld", {24'd0, wIdx}, 32'd4);
    end
    outReady = 1'b1;
    waitDone(30);

    // Abort mid-sequence, with and without an overflow already flagged
    runAbort(10, 5, 1'b0);
    runAbort(20, 15, 1'b1);

    // len = 0 gives a done pulse and no term
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd0; seed0 = 8'd5; len = '0;
    @(posedge clk); #1;
    start = 1'b0; len = 8'd9;
    @(negedge clk);
    checkOutput("len0Done", {31'd0, wDone}, 32'd1);
    checkOutput("len0Valid", {31'd0, wValid}, 32'd0);
    checkOutput("len0Busy", {31'd0, wBusy}, 32'd0);
    @(negedge clk);
    checkOutput("len0DoneOnce", {31'd0, wDone}, 32'd0);
    checkOutput("len0NoValid", {31'd0, wValid}, 32'd0);

    // Start while busy, then start during FIN: both ignored
    applyStimulus(2'd0, 0, 1, 0, 10, 1'b0);
    start = 1'b1; mode = 2'd1; seed0 = 8'd50; seed1 = 8'd60; len = 8'd3;
    @(posedge clk); #1;
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      if (wValid && wLast) found = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    checkOutput("busyLastReached", {31'd0, found}, 32'd1);
    @(posedge clk); #1;
    start = 1'b1; mode = 2'd0; seed0 = 8'd9; len = 8'd5;
    @(negedge clk);
    checkOutput("finDone", {31'd0, wDone}, 32'd1);
    @(posedge clk); #1;
    start = 1'b0;
    sawValid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      sawValid = sawValid | wValid | wBusy;
    end
    checkOutput("finStartIgnored", {31'd0, sawValid}, 32'd0);
    checkOutput("busyStartIgnored", expW.size(), 0);
    flushQueues();

    // Abort and start in the same idle cycle: start wins
    applyStimulus(2'd3, 0, 1, 0, 6, 1'b1);
    waitDone(30);

    // Reset during RUN, then a clean restart
    applyStimulus(2'd0, 5, 7, 0, 10, 1'b0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", {31'd0, wValid}, 32'd0);
    checkOutput("midRstLast", {31'd0, wLast}, 32'd0);
    checkOutput("midRstBusy", {31'd0, wBusy}, 32'd0);
    checkOutput("midRstData", {24'd0, wData}, 32'd0);
    checkOutput("midRstIdx", {24'd0, wIdx}, 32'd0);
    checkOutput("midRstOvf", {31'd0, wOvf}, 32'd0);
    flushQueues();
    @(posedge clk); #1;
    rst_n = 1'b1;
    applyStimulus(vecs[0].mode, vecs[0].s0, vecs[0].s1, vecs[0].s2, vecs[0].len, 1'b0);
    waitDone(40);
    checkOutput("postRstLast", {24'd0, lastDataW}, 32'd34);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
